// File: rtl/btn_event_ctrl_pkg.sv
// Shared event codes and per-button hold FSM state encoding for the button event controller.
package btn_event_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_RPT  = 2'd2
    } state_e;

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_LONG    = 2'd1;
    localparam logic [1:0] EV_REPEAT  = 2'd2;
    localparam logic [1:0] EV_RELEASE = 2'd3;

endpackage

// File: rtl/btn_event_ctrl_hold_fsm.sv
// Per-button hold timing: edge detect, IDLE/DOWN/RPT FSM with shared counter,
// and a single-entry pending slot that records a sticky overflow on drops.
module btn_hold_fsm
    import btn_event_ctrl_pkg::*;
#(
    parameter int LONG_CYC = 13500000,
    parameter int REP_CYC  = 2700000,
    parameter int CNT_BITS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       grant,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       held,
    output logic       overflow
);

    localparam logic [CNT_BITS-1:0] LONG_TC = CNT_BITS'(LONG_CYC - 1);
    localparam logic [CNT_BITS-1:0] REP_TC  = CNT_BITS'(REP_CYC - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic                prev_q;
    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                pend_valid_q, pend_valid_d;
    logic [1:0]          pend_type_q, pend_type_d;
    logic                overflow_q, overflow_d;
    logic                rise_s, fall_s, emit_s;
    logic [1:0]          emit_type_s;

    assign rise_s = btn & ~prev_q;
    assign fall_s = ~btn & prev_q;

    // Hold FSM: a fall always beats a coincident terminal count.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        emit_s      = 1'b0;
        emit_type_s = EV_PRESS;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    emit_s      = 1'b1;
                    emit_type_s = EV_PRESS;
                    count_d     = '0;
                    state_d     = ST_DOWN;
                end else begin
                    count_d = count_q;
                end
            end
            ST_DOWN: begin
                if (fall_s) begin
                    emit_s      = 1'b1;
                    emit_type_s = EV_RELEASE;
                    state_d     = ST_IDLE;
                end else if (count_q == LONG_TC) begin
                    emit_s      = 1'b1;
                    emit_type_s = EV_LONG;
                    count_d     = '0;
                    state_d     = ST_RPT;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            ST_RPT: begin
                if (fall_s) begin
                    emit_s      = 1'b1;
                    emit_type_s = EV_RELEASE;
                    state_d     = ST_IDLE;
                end else if (count_q == REP_TC) begin
                    emit_s      = 1'b1;
                    emit_type_s = EV_REPEAT;
                    count_d     = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Pending slot: a grant in the same cycle frees room for the new event.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_type_d  = pend_type_q;
        overflow_d   = overflow_q;
        if (emit_s) begin
            if (pend_valid_q && !grant) begin
                overflow_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_type_d  = emit_type_s;
            end
        end else if (grant) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // State registers; prev samples the live level on reset so a held button stays silent.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q       <= btn;
            state_q      <= ST_IDLE;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_type_q  <= EV_PRESS;
            overflow_q   <= 1'b0;
        end else begin
            prev_q       <= btn;
            state_q      <= state_d;
            count_q      <= count_d;
            pend_valid_q <= pend_valid_d;
            pend_type_q  <= pend_type_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_type  = pend_type_q;
    assign held       = (state_q != ST_IDLE);
    assign overflow   = overflow_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller top: one hold FSM per button, round-robin arbiter
// and a valid/ready output register carrying (button, event type).
module btn_event_ctrl
    import btn_event_ctrl_pkg::*;
#(
    parameter int NBTN     = 4,
    parameter int IDW      = 2,
    parameter int LONG_CYC = 13500000,
    parameter int REP_CYC  = 2700000,
    parameter int CNT_BITS = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_clean,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [IDW-1:0]  ev_btn,
    output logic [1:0]      ev_type,
    output logic [NBTN-1:0] held,
    output logic [NBTN-1:0] overflow
);

    logic [NBTN-1:0] pend_valid_s;
    logic [1:0]      pend_type_s [NBTN];
    logic [NBTN-1:0] grant_s;
    logic [IDW-1:0]  grant_idx_s, idx_s;
    logic            found_s, load_s;
    logic [IDW-1:0]  rr_q, rr_d;
    logic            ev_valid_q, ev_valid_d;
    logic [IDW-1:0]  ev_btn_q, ev_btn_d;
    logic [1:0]      ev_type_q, ev_type_d;

    for (genvar g = 0; g < NBTN; g++) begin : g_btn
        btn_hold_fsm #(
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC),
            .CNT_BITS (CNT_BITS)
        ) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .btn        (btn_clean[g]),
            .grant      (grant_s[g]),
            .pend_valid (pend_valid_s[g]),
            .pend_type  (pend_type_s[g]),
            .held       (held[g]),
            .overflow   (overflow[g])
        );
    end

    // Round-robin search: first valid slot at or after rr, wrapping.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        idx_s       = '0;
        for (int k = 0; k < NBTN; k++) begin
            idx_s = IDW'((int'(rr_q) + k) % NBTN);
            if (!found_s && pend_valid_s[idx_s]) begin
                found_s     = 1'b1;
                grant_idx_s = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        load_s  = (!ev_valid_q || ev_ready) && found_s;
        grant_s = '0;
        if (load_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Output register: load on free/accepted output, otherwise hold or drain.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_btn_d   = ev_btn_q;
        ev_type_d  = ev_type_q;
        rr_d       = rr_q;
        if (load_s) begin
            ev_valid_d = 1'b1;
            ev_btn_d   = grant_idx_s;
            ev_type_d  = pend_type_s[grant_idx_s];
            rr_d       = IDW'((int'(grant_idx_s) + 1) % NBTN);
        end else if (ev_ready) begin
            ev_valid_d = 1'b0;
        end else begin
            ev_valid_d = ev_valid_q;
        end
    end

    // Arbiter pointer and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q       <= '0;
            ev_valid_q <= 1'b0;
            ev_btn_q   <= '0;
            ev_type_q  <= EV_PRESS;
        end else begin
            rr_q       <= rr_d;
            ev_valid_q <= ev_valid_d;
            ev_btn_q   <= ev_btn_d;
            ev_type_q  <= ev_type_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_btn   = ev_btn_q;
    assign ev_type  = ev_type_q;

endmodule
